// File: rtl/round_scoreboard_if.sv
// -----------------------------------------------------------------------------
// round_scoreboard_if
//   Round-won event bus from the round-end detector into the scoreboard.
//
//   Signals:
//     win_pulse : one-cycle pulse, a round was won
//     win_left  : qualifies win_pulse, 1 = left player won, 0 = right player won
//
//   Modports:
//     master : the round-end detector (drives the event)
//     slave  : the scoreboard (consumes the event)
// -----------------------------------------------------------------------------
interface round_scoreboard_if;
  logic win_pulse;
  logic win_left;

  modport master (
    output win_pulse,
    output win_left
  );

  modport slave (
    input win_pulse,
    input win_left
  );
endinterface : round_scoreboard_if

// File: rtl/round_scoreboard.sv
// -----------------------------------------------------------------------------
// round_scoreboard
//   Tug-of-war game scoreboard. It sits downstream of the round-end detector,
//   counts round wins per player, shows both counts on active-low 7-segment
//   digits and holds the playfield in reset for a fixed time after every
//   non-final win. When either player reaches MAX_SCORE the game is over.
//
//   Optional feature (macro AUTO_RESTART_EN):
//     defined   : GAME_OVER lasts RESTART_CYCLES cycles, then scores clear and
//                 play resumes automatically.
//     undefined : GAME_OVER is terminal until reset; no restart counter exists.
//
//   Parameters:
//     MAX_SCORE      : wins needed to end the game (1..9)
//     HOLD_CYCLES    : cycles round_reset stays high after a non-final win (>=1)
//     RESTART_CYCLES : game-over dwell before auto restart (AUTO_RESTART_EN only)
//
//   Ports:
//     clk             in   system clock
//     reset           in   synchronous, active-high, overrides everything
//     i_win           in   round_scoreboard_if.slave (win_pulse, win_left)
//     o_score_l [3:0] out  left win count, registered
//     o_score_r [3:0] out  right win count, registered
//     o_hex_l   [6:0] out  active-low 7-seg of o_score_l, {g,f,e,d,c,b,a}
//     o_hex_r   [6:0] out  active-low 7-seg of o_score_r
//     o_round_reset   out  registered; clears the playfield while high
//     o_game_over     out  registered; high in GAME_OVER
//     o_winner_left   out  registered; valid while o_game_over, 1 = left won
// -----------------------------------------------------------------------------
module round_scoreboard #(
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
`ifdef AUTO_RESTART_EN
  ,
  parameter int RESTART_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  round_scoreboard_if.slave  i_win,
  output logic [3:0]         o_score_l,
  output logic [3:0]         o_score_r,
  output logic [6:0]         o_hex_l,
  output logic [6:0]         o_hex_r,
  output logic               o_round_reset,
  output logic               o_game_over,
  output logic               o_winner_left
);

  // Hold counter only has to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [3:0]        MAX_S     = 4'(MAX_SCORE);

`ifdef AUTO_RESTART_EN
  localparam int RST_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [RST_W-1:0] RESTART_LOAD = RST_W'(RESTART_CYCLES - 1);
  localparam logic [RST_W-1:0] RESTART_ZERO = {RST_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_ROUND_END = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_score_l;
  logic [3:0]        r_score_r;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_round_reset;
  logic              r_game_over;
  logic              r_winner_left;
`ifdef AUTO_RESTART_EN
  logic [RST_W-1:0]  r_restart_cnt;
`endif

  logic [3:0]        w_score_l_inc;
  logic [3:0]        w_score_r_inc;
  logic [3:0]        w_win_score;

  // Active-low 7-segment decode, {g,f,e,d,c,b,a}; non-decimal values blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Candidate post-win score of whichever player the current pulse names.
  always_comb begin
    w_score_l_inc = r_score_l + 4'd1;
    w_score_r_inc = r_score_r + 4'd1;
    if (i_win.win_left) begin
      w_win_score = w_score_l_inc;
    end else begin
      w_win_score = w_score_r_inc;
    end
  end

  // Scoreboard FSM: scores, hold timing, game-over flags (all registered).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_PLAY;
      r_score_l     <= 4'd0;
      r_score_r     <= 4'd0;
      r_hold_cnt    <= HOLD_ZERO;
      r_round_reset <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner_left <= 1'b0;
`ifdef AUTO_RESTART_EN
      r_restart_cnt <= RESTART_ZERO;
`endif
    end else begin
      case (r_state)
        ST_PLAY: begin
          // Only PLAY accepts a win, so a held pulse counts exactly once
          // and scores can never pass MAX_SCORE.
          if (i_win.win_pulse) begin
            if (i_win.win_left) begin
              r_score_l <= w_score_l_inc;
            end else begin
              r_score_r <= w_score_r_inc;
            end
            r_round_reset <= 1'b1;
            if (w_win_score == MAX_S) begin
              r_state       <= ST_GAME_OVER;
              r_game_over   <= 1'b1;
              r_winner_left <= i_win.win_left;
`ifdef AUTO_RESTART_EN
              r_restart_cnt <= RESTART_LOAD;
`endif
            end else begin
              r_state    <= ST_ROUND_END;
              r_hold_cnt <= HOLD_LOAD;
            end
          end else begin
            r_round_reset <= 1'b0;
          end
        end

        ST_ROUND_END: begin
          // Counter was loaded with HOLD_CYCLES-1, so round_reset stays high
          // for HOLD_CYCLES cycles and drops on the edge that sees zero.
          // A pulse arriving on that exit edge is dropped on purpose.
          if (r_hold_cnt == HOLD_ZERO) begin
            r_state       <= ST_PLAY;
            r_round_reset <= 1'b0;
          end else begin
            r_hold_cnt    <= r_hold_cnt - {{(HOLD_W-1){1'b0}}, 1'b1};
            r_round_reset <= 1'b1;
          end
        end

        ST_GAME_OVER: begin
`ifdef AUTO_RESTART_EN
          // Dwell of RESTART_CYCLES cycles, then a fresh game.
          if (r_restart_cnt == RESTART_ZERO) begin
            r_state       <= ST_PLAY;
            r_score_l     <= 4'd0;
            r_score_r     <= 4'd0;
            r_round_reset <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner_left <= 1'b0;
          end else begin
            r_restart_cnt <= r_restart_cnt - {{(RST_W-1){1'b0}}, 1'b1};
            r_round_reset <= 1'b1;
            r_game_over   <= 1'b1;
          end
`else
          // Terminal until reset; scores frozen, playfield held cleared.
          r_round_reset <= 1'b1;
          r_game_over   <= 1'b1;
`endif
        end

        default: begin
          // Unreachable encoding: recover into a clean PLAY state.
          r_state       <= ST_PLAY;
          r_round_reset <= 1'b0;
          r_game_over   <= 1'b0;
          r_winner_left <= 1'b0;
        end
      endcase
    end
  end

  assign o_score_l     = r_score_l;
  assign o_score_r     = r_score_r;
  assign o_round_reset = r_round_reset;
  assign o_game_over   = r_game_over;
  assign o_winner_left = r_winner_left;

  // Digits follow the score registers directly, so they change with them.
  assign o_hex_l = seg7_decode(r_score_l);
  assign o_hex_r = seg7_decode(r_score_r);

endmodule : round_scoreboard

// File: tb/tb_round_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_round_scoreboard
//   Directed-vector bench for round_scoreboard with default parameters
//   (MAX_SCORE=7, HOLD_CYCLES=4, RESTART_CYCLES=16). Inputs change and outputs
//   are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_round_scoreboard;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic       round_reset;
  logic       game_over;
  logic       winner_left;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [0:9];

  round_scoreboard_if u_if ();

  round_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .i_win         (u_if),
    .o_score_l     (score_l),
    .o_score_r     (score_r),
    .o_hex_l       (hex_l),
    .o_hex_r       (hex_r),
    .o_round_reset (round_reset),
    .o_game_over   (game_over),
    .o_winner_left (winner_left)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic left);
    u_if.win_pulse = 1'b1;
    u_if.win_left  = left;
    step();
    u_if.win_pulse = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_score_l"},     32'(score_l),     32'd0);
    check_eq({tag, "_score_r"},     32'(score_r),     32'd0);
    check_eq({tag, "_hex_l"},       32'(hex_l),       32'h40);
    check_eq({tag, "_hex_r"},       32'(hex_r),       32'h40);
    check_eq({tag, "_round_reset"}, 32'(round_reset), 32'd0);
    check_eq({tag, "_game_over"},   32'(game_over),   32'd0);
    check_eq({tag, "_winner_left"}, 32'(winner_left), 32'd0);
  endtask

  initial begin
    int n;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    reset          = 1'b1;
    u_if.win_pulse = 1'b0;
    u_if.win_left  = 1'b0;
    step_n(2);
    check_reset_vals("rst");
    reset = 1'b0;
    step_n(5);
    check_reset_vals("idle");

    // Single left win: one-cycle latency, round_reset high for 4 cycles
    pulse(1'b1);
    check_eq("w1_score_l", 32'(score_l), 32'd1);
    check_eq("w1_hex_l",   32'(hex_l),   32'h79);
    check_eq("w1_score_r", 32'(score_r), 32'd0);
    n = 0;
    for (int i = 0; i < 10 && round_reset; i++) begin
      n++;
      step();
    end
    check_eq("w1_rr_len", 32'(n), 32'd4);
    check_eq("w1_game_over", 32'(game_over), 32'd0);

    // Right pulse held for 3 cycles counts once
    u_if.win_pulse = 1'b1;
    u_if.win_left  = 1'b0;
    step_n(3);
    u_if.win_pulse = 1'b0;
    check_eq("held_score_r", 32'(score_r), 32'd1);
    check_eq("held_score_l", 32'(score_l), 32'd1);
    check_eq("held_hex_r",   32'(hex_r),   32'h79);
    for (int i = 0; i < 10 && round_reset; i++) step();
    check_eq("held_rr_fell", 32'(round_reset), 32'd0);

    // Pulse in the first PLAY cycle after ROUND_END is counted
    pulse(1'b0);
    check_eq("first_play_score_r", 32'(score_r), 32'd2);
    check_eq("first_play_hex_r",   32'(hex_r),   32'h24);

    // Pulse on the edge where ROUND_END exits is ignored
    step_n(3);
    check_eq("exit_edge_rr_before", 32'(round_reset), 32'd1);
    pulse(1'b0);
    check_eq("exit_edge_rr_after", 32'(round_reset), 32'd0);
    check_eq("exit_edge_score_r",  32'(score_r),     32'd2);

    // Right wins up to MAX_SCORE, spaced 6 cycles apart
    for (int k = 3; k <= 7; k++) begin
      pulse(1'b0);
      check_eq($sformatf("run_score_r_%0d", k), 32'(score_r), 32'(k));
      check_eq($sformatf("run_hex_r_%0d", k),   32'(hex_r),   32'(seg_tab[k]));
      if (k < 7) step_n(5);
    end
    check_eq("go_game_over",   32'(game_over),   32'd1);
    check_eq("go_winner_left", 32'(winner_left), 32'd0);
    check_eq("go_round_reset", 32'(round_reset), 32'd1);
    check_eq("go_hex_r",       32'(hex_r),       32'h78);

    // Pulses during GAME_OVER are ignored
    u_if.win_pulse = 1'b1;
    u_if.win_left  = 1'b1;
    step_n(3);
    u_if.win_pulse = 1'b0;
    check_eq("go_frozen_l",  32'(score_l),     32'd1);
    check_eq("go_frozen_r",  32'(score_r),     32'd7);
    check_eq("go_still_go", 32'(game_over),   32'd1);
    check_eq("go_still_rr", 32'(round_reset), 32'd1);

    // Reset from GAME_OVER, then reset in the 2nd ROUND_END cycle
    reset = 1'b1;
    step();
    check_reset_vals("rst_go");
    reset = 1'b0;
    step();
    pulse(1'b1);
    check_eq("re1_rr", 32'(round_reset), 32'd1);
    step();
    check_eq("re2_rr", 32'(round_reset), 32'd1);
    reset = 1'b1;
    step();
    check_reset_vals("rst_re");
    reset = 1'b0;
    step();

    // Left player wins the game
    for (int k = 1; k <= 6; k++) begin
      pulse(1'b1);
      step_n(5);
    end
    pulse(1'b1);
    check_eq("lgo_game_over",   32'(game_over),   32'd1);
    check_eq("lgo_winner_left", 32'(winner_left), 32'd1);
    check_eq("lgo_score_l",     32'(score_l),     32'd7);
    check_eq("lgo_hex_l",       32'(hex_l),       32'h78);
    check_eq("lgo_score_r",     32'(score_r),     32'd0);

`ifdef AUTO_RESTART_EN
    // Game-over dwell of 16 cycles, then a fresh game in PLAY
    n = 0;
    for (int i = 0; i < 40 && game_over; i++) begin
      n++;
      step();
    end
    check_eq("auto_dwell", 32'(n), 32'd16);
    check_reset_vals("auto_restart");
    pulse(1'b0);
    check_eq("auto_play_score_r", 32'(score_r), 32'd1);
`else
    // Without auto restart GAME_OVER is terminal
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (game_over) n++;
      step();
    end
    check_eq("term_dwell",   32'(n),           32'd100);
    check_eq("term_score_l", 32'(score_l),     32'd7);
    check_eq("term_rr",      32'(round_reset), 32'd1);
    check_eq("term_winner",  32'(winner_left), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_round_scoreboard

// File: doc/round_scoreboard.md
Name: round_scoreboard

Overview:
- Downstream of the round-end detector in the tug-of-war game.
- Consumes the one-cycle round-won pulse and the winner side, then keeps per-player win counts and shows them on two 7-segment digits.
- Drives the playfield round-restart line for a fixed hold time, and declares game over when either player reaches MAX_SCORE.

Parameters:
- MAX_SCORE, 7, wins needed to end the game; legal range 1..9.
- HOLD_CYCLES, 4, number of cycles round_reset stays high after each non-final win; legal range ≥1.
- RESTART_CYCLES, 16, game-over dwell before automatic restart; used only with AUTO_RESTART_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- win_pulse  in  1  one-cycle pulse: a round was won
- win_left  in  1  qualifies win_pulse: 1 = left player won, 0 = right player won
- score_l  out  4  left win count, registered
- score_r  out  4  right win count, registered
- hex_l  out  7  active-low 7-seg pattern for score_l, segments {g,f,e,d,c,b,a}
- hex_r  out  7  active-low 7-seg pattern for score_r
- round_reset  out  1  registered; clears the playfield while high
- game_over  out  1  registered; high in GAME_OVER
- winner_left  out  1  registered; valid while game_over=1, 1 = left player won the game

Behaviour:
- Clock, reset: clk; reset is synchronous, active-high. It overrides all other inputs.
- Reset values:
  - state=PLAY
  - score_l=score_r=0
  - round_reset=0, game_over=0, winner_left=0
  - hold counter=0
  - hex_l=hex_r=7'b1000000
- State PLAY:
  - win_pulse=0: no change.
  - win_pulse=1: the winner's score increments on the next edge.
  - If the incremented value equals MAX_SCORE: go to GAME_OVER. game_over=1 and winner_left=win_left, both from the next cycle.
  - Otherwise: go to ROUND_END. The hold counter loads HOLD_CYCLES-1.
- State ROUND_END:
  - round_reset=1 for exactly HOLD_CYCLES consecutive cycles, starting the cycle after the win_pulse edge.
  - The counter decrements each cycle. At 0 the block returns to PLAY and round_reset drops on that edge.
  - win_pulse is ignored here; no score change.
- State GAME_OVER:
  - round_reset=1 and game_over=1 continuously.
  - Scores are frozen and win_pulse is ignored.
  - Exit only via reset, or via auto-restart when AUTO_RESTART_EN is defined.
- Latency: win_pulse to score/round_reset/game_over change is 1 cycle.
- Score width and saturation: scores never exceed MAX_SCORE. An increment is only possible in PLAY, and reaching MAX_SCORE leaves PLAY.
- Display encoding:
  - hex_l/hex_r are combinational decodes of the score registers.
  - Table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value decodes to 1111111 (blank).
- Boundary cases:
  - win_pulse held high for several cycles in PLAY: only the first cycle counts, because the state leaves PLAY.
  - win_pulse on the same edge that ROUND_END exits to PLAY: ignored, since it is sampled in ROUND_END.
  - win_pulse in the first PLAY cycle after ROUND_END: counted.
  - reset asserted mid-ROUND_END or mid-GAME_OVER: full return to reset values on that edge.
  - HOLD_CYCLES=1: round_reset is a single-cycle pulse.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- Defined:
  - On entering GAME_OVER, a restart counter loads RESTART_CYCLES-1 and decrements each cycle.
  - At 0, the next edge clears scores, game_over and winner_left, and goes to PLAY with round_reset=0.
  - Total game-over dwell is RESTART_CYCLES cycles.
- Not defined: GAME_OVER is terminal until reset, and no restart counter is synthesized.

Test Plan:
- Reset, then idle 5 cycles -> scores 0, hex both 1000000, round_reset=0, game_over=0.
- One win_pulse with win_left=1 -> next cycle score_l=1, hex_l=1111001, round_reset high exactly 4 cycles; score_r stays 0.
- win_pulse held high 3 cycles with win_left=0 -> score_r=1 only. Then a pulse one cycle after round_reset falls -> score_r=2.
- 7 right wins spaced by 6 cycles each -> score_r=7, hex_r=1111000, game_over=1, winner_left=0, round_reset held high. Further pulses leave scores unchanged.
- reset asserted during the 2nd ROUND_END cycle -> next cycle all reset values, round_reset=0.
- With AUTO_RESTART_EN, reach game over -> after 16 cycles scores 0, game_over=0, round_reset=0, state PLAY. Without the macro, game_over stays 1 for 100 cycles.
